micro_ent_sequencer: RTL and testbench

Sequencer that sits directly upstream of the Micro_ent servo stage and drives its 2-bit `command` input. It turns a single `start` request into a timed sequence of servo positions: interior (01), exterior (10), oscillate (11) and aligned (00), holding each for a programmable dwell. It reports progress to the host-side control logic through `busy` and `done`, and supports `abort`.

---
 rtl/micro_ent_sequencer.sv | 145 ++++++++++++++
 tb/tb_micro_ent_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/micro_ent_sequencer.sv
// Timed command sequencer for the Micro_ent servo stage: one start request drives a dwell-timed command sequence.
// Latency: start/abort sampled at an edge are visible on command/busy/state_dbg after that same edge; done is registered too.
// Backpressure: none; start is ignored while busy (no queuing), and abort or reset returns to IDLE without a done pulse.
module micro_ent_sequencer #(
  parameter int unsigned DWELL_IN   = 25_000_000,
  parameter int unsigned DWELL_OUT  = 25_000_000,
  parameter int unsigned WIGGLE_LEN = 50_000_000,
  parameter int unsigned SETTLE_LEN = 25_000_000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] seq_sel,
  input  logic       abort,
  output logic [1:0] command,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INT    = 3'd1,
    ST_EXT    = 3'd2,
    ST_WIG    = 3'd3,
    ST_SETTLE = 3'd4
  } state_t;

  localparam logic [1:0] SEL_DEPLOY  = 2'b00;
  localparam logic [1:0] SEL_RETRACT = 2'b01;
  localparam logic [1:0] SEL_FULL    = 2'b10;

  // Counter reload values: a state is held while the counter walks down to zero,
  // so loading length-1 gives exactly length cycles in the state.
  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(DWELL_IN - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(DWELL_OUT - 1);
  localparam logic [CNT_W-1:0] WIG_LAST = CNT_W'(WIGGLE_LEN - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       cmd_q, cmd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state, dwell counter and latched selection; outputs decoded from the next state
  // so they land on the same edge as the state itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    cmd_d   = 2'b00;
    busy_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          sel_d = seq_sel;
          case (seq_sel)
            SEL_DEPLOY, SEL_FULL: begin state_d = ST_INT; cnt_d = IN_LAST;  end
            SEL_RETRACT:          begin state_d = ST_EXT; cnt_d = OUT_LAST; end
            default:              begin state_d = ST_WIG; cnt_d = WIG_LAST; end
          endcase
        end
      end
      ST_INT: begin
        if (cnt_q == '0) begin
          if (sel_q == SEL_FULL) begin
            state_d = ST_EXT;
            cnt_d   = OUT_LAST;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = SET_LAST;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_EXT, ST_WIG: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = SET_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides everything in an active sequence, suppressing done.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    case (state_d)
      ST_INT:  cmd_d = 2'b01;
      ST_EXT:  cmd_d = 2'b10;
      ST_WIG:  cmd_d = 2'b11;
      default: cmd_d = 2'b00;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      cmd_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign command   = cmd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_micro_ent_sequencer.sv
// Bench for micro_ent_sequencer: per-cycle expected outputs are queued from the sequence timing, then popped each cycle.
// Latency: every cycle after an edge is compared against the next queued entry.
// Backpressure: not applicable; stimulus is driven at fixed cycles.
module tb_micro_ent_sequencer;

  localparam logic [1:0] C_IDLE = 2'b00;
  localparam logic [1:0] C_INT  = 2'b01;
  localparam logic [1:0] C_EXT  = 2'b10;
  localparam logic [1:0] C_WIG  = 2'b11;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INT  = 3'd1;
  localparam logic [2:0] S_EXT  = 3'd2;
  localparam logic [2:0] S_WIG  = 3'd3;
  localparam logic [2:0] S_SET  = 3'd4;

  typedef struct packed {
    logic [1:0] cmd;
    logic       busy;
    logic       done;
    logic [2:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] seq_sel;
  logic       abort;
  logic [1:0] command;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  string scen  = "init";

  micro_ent_sequencer #(
    .DWELL_IN  (4),
    .DWELL_OUT (6),
    .WIGGLE_LEN(5),
    .SETTLE_LEN(3),
    .CNT_W     (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .seq_sel  (seq_sel),
    .abort    (abort),
    .command  (command),
    .busy     (busy),
    .done     (done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s/%s cycle %0d: got %0h expected %0h", scen, tag, cyc, obs, exp);
    end
  endtask

  // Queue n cycles of expected outputs; busy follows from the expected state.
  task automatic push_n(input logic [1:0] cmd, input logic [2:0] st, input logic dn, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cmd  = cmd;
      e.st   = st;
      e.done = dn;
      e.busy = (st != S_IDLE);
      sb.push_back(e);
    end
  endtask

  // Advance n edges, comparing the DUT against the scoreboard after each one.
  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() == 0) begin
        chk_val("sb_underflow", 8'd0, 8'd1);
      end else begin
        e = sb.pop_front();
        chk_val("command", {6'd0, command}, {6'd0, e.cmd});
        chk_val("busy", {7'd0, busy}, {7'd0, e.busy});
        chk_val("done", {7'd0, done}, {7'd0, e.done});
        chk_val("state_dbg", {5'd0, state_dbg}, {5'd0, e.st});
      end
    end
  endtask

  task automatic push_full_cycle();
    push_n(C_INT, S_INT, 1'b0, 4);
    push_n(C_EXT, S_EXT, 1'b0, 6);
    push_n(C_IDLE, S_SET, 1'b0, 3);
    push_n(C_IDLE, S_IDLE, 1'b1, 1);
    push_n(C_IDLE, S_IDLE, 1'b0, 2);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    seq_sel = 2'b00;
    abort   = 1'b0;

    scen = "reset";
    push_n(C_IDLE, S_IDLE, 1'b0, 3);
    run(2);
    reset = 1'b0;
    run(1);

    // Full cycle.
    scen = "full";
    push_full_cycle();
    seq_sel = 2'b10; start = 1'b1;
    run(1);
    start = 1'b0;
    run(15);

    // Deploy, then retract started in the done cycle.
    scen = "deploy_retract";
    push_n(C_INT, S_INT, 1'b0, 4);
    push_n(C_IDLE, S_SET, 1'b0, 3);
    push_n(C_IDLE, S_IDLE, 1'b1, 1);
    push_n(C_EXT, S_EXT, 1'b0, 6);
    push_n(C_IDLE, S_SET, 1'b0, 3);
    push_n(C_IDLE, S_IDLE, 1'b1, 1);
    push_n(C_IDLE, S_IDLE, 1'b0, 2);
    seq_sel = 2'b00; start = 1'b1;
    run(1);
    start = 1'b0;
    run(7);
    seq_sel = 2'b01; start = 1'b1;
    run(1);
    start = 1'b0;
    run(11);

    // Wiggle with seq_sel changed mid-run.
    scen = "wiggle";
    push_n(C_WIG, S_WIG, 1'b0, 5);
    push_n(C_IDLE, S_SET, 1'b0, 3);
    push_n(C_IDLE, S_IDLE, 1'b1, 1);
    push_n(C_IDLE, S_IDLE, 1'b0, 2);
    seq_sel = 2'b11; start = 1'b1;
    run(1);
    start = 1'b0;
    run(1);
    seq_sel = 2'b00;
    run(9);

    // Abort during EXT of a full cycle.
    scen = "abort";
    push_n(C_INT, S_INT, 1'b0, 4);
    push_n(C_EXT, S_EXT, 1'b0, 3);
    push_n(C_IDLE, S_IDLE, 1'b0, 6);
    seq_sel = 2'b10; start = 1'b1;
    run(1);
    start = 1'b0;
    run(6);
    abort = 1'b1;
    run(1);
    abort = 1'b0;
    run(5);

    // Start pulses while busy are ignored.
    scen = "start_busy";
    push_full_cycle();
    seq_sel = 2'b10; start = 1'b1;
    run(1);
    start = 1'b0;
    run(1);
    start = 1'b1; seq_sel = 2'b11;
    run(1);
    start = 1'b0; seq_sel = 2'b10;
    run(9);
    start = 1'b1;
    run(1);
    start = 1'b0;
    run(3);

    // Start and abort together in IDLE: abort wins.
    scen = "start_abort";
    push_n(C_IDLE, S_IDLE, 1'b0, 4);
    seq_sel = 2'b10; start = 1'b1; abort = 1'b1;
    run(2);
    start = 1'b0; abort = 1'b0;
    run(2);

    // Reset mid-WIG, then a clean full cycle.
    scen = "reset_mid";
    push_n(C_WIG, S_WIG, 1'b0, 3);
    push_n(C_IDLE, S_IDLE, 1'b0, 5);
    seq_sel = 2'b11; start = 1'b1;
    run(1);
    start = 1'b0;
    run(2);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(4);

    scen = "full_after_reset";
    push_full_cycle();
    seq_sel = 2'b10; start = 1'b1;
    run(1);
    start = 1'b0;
    run(15);

    scen = "end";
    chk_val("sb_drained", 8'(sb.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
